loop_replay_controller: RTL and testbench
=========================================

Name: loop_replay_controller

Overview:
Fetch-side sequencer that owns the loop stream buffer. It trains on repeated taken backward branches from the IF/ID stage and captures one loop-body iteration into local storage. It then replays that body into ID while freezing PC/I-cache fetch. On mispredict it terminates replay, flushes and redirects the front end.

Parameters:
DEPTH, 16, maximum loop-body length in instructions (power of two)
PTR_W, 4, log2(DEPTH)
TRIP_THRESH, 2, consecutive identical taken backward branches required before capture (>=1)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high
if_valid  in  1  IF/ID holds a valid instruction this cycle
if_pc  in  32  PC of the IF/ID instruction
if_instr  in  32  IF/ID instruction word
br_taken  in  1  branch in IF/ID resolved/predicted taken this cycle
br_pc  in  32  PC of that branch
br_target  in  32  target of that branch
mispredict  in  1  EX reports misprediction
mispredict_pc  in  32  correct next PC from EX
stall  in  1  ID cannot accept a replayed instruction
fetch_block  out  1  freeze PC register and I-cache fetch
replay_valid  out  1  replay_pc/replay_instr valid to ID
replay_pc  out  32  PC of replayed instruction
replay_instr  out  32  replayed instruction word
flush  out  1  one-cycle pipeline flush pulse
redirect_valid  out  1  one-cycle front-end redirect
redirect_pc  out  32  redirect address
state  out  2  IDLE=0, TRAIN=1, CAPTURE=2, REPLAY=3
loop_len  out  PTR_W+1  captured body length (0 when not REPLAY)

Behaviour:
- Reset wins over all inputs. Next edge: state=IDLE, all outputs 0, counters/pointers 0. Buffer contents are don't-care.
- Priority per edge: reset > mispredict > everything else.
- Candidate branch: br_taken & br_target<br_pc (unsigned) & br_pc[1:0]==0 & br_target[1:0]==0 & body_len<=DEPTH.
- body_len = ((br_pc-br_target)>>2)+1. Compute it in 32 bits before comparing.
- IDLE: on a candidate, latch tag_pc=br_pc and tag_tgt=br_target, set iter=1. If TRIP_THRESH==1 go to CAPTURE, else go to TRAIN.
- TRAIN, same-tag candidate: iter++. When iter+1==TRIP_THRESH, go to CAPTURE with wr_ptr=0.
- TRAIN, different-tag candidate: re-latch the tag, iter=1, stay in TRAIN.
- TRAIN, non-candidate taken branch: go to IDLE.
- CAPTURE: on if_valid with if_pc==tag_tgt+4*wr_ptr, write buf[wr_ptr]=if_instr and increment wr_ptr.
- CAPTURE completion: when the written if_pc==tag_pc, go to REPLAY with loop_len=wr_ptr+1 and rd_ptr=0.
- CAPTURE abort: go to IDLE on any of:
  - if_valid with a non-matching if_pc;
  - wr_ptr reaching DEPTH without seeing tag_pc.
- REPLAY: fetch_block=1, registered and asserted from the first REPLAY cycle.
- replay_valid=1 every REPLAY cycle, with replay_instr=buf[rd_ptr] and replay_pc=tag_tgt+4*rd_ptr. The first cycle shows rd_ptr=0.
- rd_ptr advances only when !stall and wraps from loop_len-1 to 0.
- While stall=1, replay_pc and replay_instr hold exactly.
- Mispredict in REPLAY, next edge:
  - flush=1, redirect_valid=1, redirect_pc=mispredict_pc, each for exactly one cycle;
  - state=IDLE;
  - fetch_block, replay_valid and loop_len cleared in that same cycle.
- Mispredict in TRAIN or CAPTURE: go to IDLE with no flush/redirect, since the pipeline handles it.
- Mispredict in IDLE: no effect.
- Mispredict and a candidate on the same edge: mispredict wins and the candidate is ignored.
- flush, redirect_valid and redirect_pc are 0 except in the pulse cycle.
- Storage: DEPTH x 32 register array, one write port and one read port.

Test Plan:
- Reset: assert reset 2 cycles mid-TRAIN -> next edge state=0, fetch_block=replay_valid=flush=redirect_valid=0, loop_len=0.
- Loop train/capture: run 0x100:13, 0x104:14, 0x108:15, 0x10C:FC000AE3 (br_taken, target 0x100) x3 iterations -> state TRAIN then CAPTURE then REPLAY; loop_len=4.
- Replay output: in REPLAY, fetch_block=1 and replay_pc repeats 0x100, 0x104, 0x108, 0x10C, 0x100 with instr 13, 14, 15, FC000AE3, 13.
- Stall: during REPLAY hold stall=1 for 3 cycles at 0x104 -> replay_pc=0x104 and replay_instr=14 all 3 cycles, then 0x108.
- Exit: during REPLAY, mispredict=1 with mispredict_pc=0x110 -> flush=1, redirect_valid=1, redirect_pc=0x110 for exactly one cycle; state=0 and fetch_block=0 that cycle.
- Boundary: br_pc=0x140/target 0x100 (len 17, DEPTH 16) -> stays IDLE.
- Boundary: len-16 loop 0x100..0x13C -> replays with loop_len=16.
- Boundary: during CAPTURE, if_pc jumps 0x104 -> 0x200 -> IDLE with no replay.
- Boundary: mispredict with a same-tag candidate in TRAIN -> IDLE.

Source files
------------

// File: rtl/loop_replay_controller.sv
// Loop stream buffer sequencer: trains on a repeating backward branch,
// captures one iteration of the loop body, then replays it into ID while
// the fetch front end is frozen. A mispredict during replay ends it with a
// flush and a redirect to the corrected PC.
module loop_replay_controller #(
   parameter int DEPTH       = 16,
   parameter int PTR_W       = 4,
   parameter int TRIP_THRESH = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             if_valid,
   input  logic [31:0]      if_pc,
   input  logic [31:0]      if_instr,
   input  logic             br_taken,
   input  logic [31:0]      br_pc,
   input  logic [31:0]      br_target,
   input  logic             mispredict,
   input  logic [31:0]      mispredict_pc,
   input  logic             stall,
   output logic             fetch_block,
   output logic             replay_valid,
   output logic [31:0]      replay_pc,
   output logic [31:0]      replay_instr,
   output logic             flush,
   output logic             redirect_valid,
   output logic [31:0]      redirect_pc,
   output logic [1:0]       state,
   output logic [PTR_W:0]   loop_len
);

   localparam int ITER_W = $clog2(TRIP_THRESH + 1);
   localparam logic [ITER_W-1:0] ITER_ONE    = ITER_W'(1);
   localparam logic [ITER_W-1:0] ITER_THRESH = ITER_W'(TRIP_THRESH);
   localparam logic [PTR_W-1:0]  PTR_ONE     = PTR_W'(1);
   localparam logic [PTR_W-1:0]  PTR_LAST    = PTR_W'(DEPTH - 1);
   localparam logic [PTR_W:0]    LEN_ONE     = (PTR_W + 1)'(1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_TRAIN   = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_REPLAY  = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [31:0]       tag_pc_q, tag_pc_d;
   logic [31:0]       tag_tgt_q, tag_tgt_d;
   logic [ITER_W-1:0] iter_q, iter_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]    loop_len_q, loop_len_d;
   logic              fetch_block_q, fetch_block_d;
   logic              replay_valid_q, replay_valid_d;
   logic [31:0]       replay_pc_q, replay_pc_d;
   logic [31:0]       replay_instr_q, replay_instr_d;
   logic              flush_q, flush_d;
   logic              redirect_valid_q, redirect_valid_d;
   logic [31:0]       redirect_pc_q, redirect_pc_d;

   logic [31:0]       mem_q [DEPTH];
   logic              mem_we;

   logic [31:0]       body_len;
   logic              cand;
   logic              same_tag;
   logic              rd_wrap;
   logic [PTR_W-1:0]  rd_nxt;

   // Word address of slot idx within the loop body starting at base.
   function automatic logic [31:0] slot_pc(input logic [31:0] base,
                                           input logic [PTR_W-1:0] idx);
      return base + {{(30 - PTR_W){1'b0}}, idx, 2'b00};
   endfunction

   // Body length is computed at full width so a far-away target cannot
   // alias into a short loop.
   assign body_len = ((br_pc - br_target) >> 2) + 32'd1;
   assign cand     = br_taken && (br_target < br_pc) && (br_pc[1:0] == 2'b00) &&
                     (br_target[1:0] == 2'b00) && (body_len <= 32'(DEPTH));
   assign same_tag = (br_pc == tag_pc_q) && (br_target == tag_tgt_q);
   assign rd_wrap  = (({1'b0, rd_ptr_q} + LEN_ONE) == loop_len_q);
   assign rd_nxt   = rd_wrap ? '0 : (rd_ptr_q + PTR_ONE);

   // Next-state and next-output computation; pulses default low every cycle.
   always_comb begin
      state_d          = state_q;
      tag_pc_d         = tag_pc_q;
      tag_tgt_d        = tag_tgt_q;
      iter_d           = iter_q;
      wr_ptr_d         = wr_ptr_q;
      rd_ptr_d         = rd_ptr_q;
      loop_len_d       = loop_len_q;
      fetch_block_d    = fetch_block_q;
      replay_valid_d   = replay_valid_q;
      replay_pc_d      = replay_pc_q;
      replay_instr_d   = replay_instr_q;
      flush_d          = 1'b0;
      redirect_valid_d = 1'b0;
      redirect_pc_d    = '0;
      mem_we           = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (!mispredict && cand) begin
               tag_pc_d  = br_pc;
               tag_tgt_d = br_target;
               iter_d    = ITER_ONE;
               wr_ptr_d  = '0;
               state_d   = (TRIP_THRESH == 1) ? ST_CAPTURE : ST_TRAIN;
            end
         end
         ST_TRAIN: begin
            if (mispredict) begin
               state_d = ST_IDLE;
            end else if (cand && same_tag) begin
               iter_d = iter_q + ITER_ONE;
               if ((iter_q + ITER_ONE) == ITER_THRESH) begin
                  wr_ptr_d = '0;
                  state_d  = ST_CAPTURE;
               end
            end else if (cand) begin
               tag_pc_d  = br_pc;
               tag_tgt_d = br_target;
               iter_d    = ITER_ONE;
            end else if (br_taken) begin
               state_d = ST_IDLE;
            end
         end
         ST_CAPTURE: begin
            if (mispredict) begin
               state_d = ST_IDLE;
            end else if (if_valid) begin
               if (if_pc == slot_pc(tag_tgt_q, wr_ptr_q)) begin
                  mem_we   = 1'b1;
                  wr_ptr_d = wr_ptr_q + PTR_ONE;
                  if (if_pc == tag_pc_q) begin
                     // Bodies are at least two long, so slot 0 is already stored.
                     state_d        = ST_REPLAY;
                     loop_len_d     = {1'b0, wr_ptr_q} + LEN_ONE;
                     rd_ptr_d       = '0;
                     fetch_block_d  = 1'b1;
                     replay_valid_d = 1'b1;
                     replay_pc_d    = tag_tgt_q;
                     replay_instr_d = mem_q[0];
                  end else if (wr_ptr_q == PTR_LAST) begin
                     state_d = ST_IDLE;
                  end
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         ST_REPLAY: begin
            if (mispredict) begin
               state_d          = ST_IDLE;
               flush_d          = 1'b1;
               redirect_valid_d = 1'b1;
               redirect_pc_d    = mispredict_pc;
               fetch_block_d    = 1'b0;
               replay_valid_d   = 1'b0;
               replay_pc_d      = '0;
               replay_instr_d   = '0;
               loop_len_d       = '0;
               rd_ptr_d         = '0;
            end else if (!stall) begin
               rd_ptr_d       = rd_nxt;
               replay_pc_d    = slot_pc(tag_tgt_q, rd_nxt);
               replay_instr_d = mem_q[rd_nxt];
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Control and output registers; reset clears everything but the body store.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q          <= ST_IDLE;
         tag_pc_q         <= '0;
         tag_tgt_q        <= '0;
         iter_q           <= '0;
         wr_ptr_q         <= '0;
         rd_ptr_q         <= '0;
         loop_len_q       <= '0;
         fetch_block_q    <= 1'b0;
         replay_valid_q   <= 1'b0;
         replay_pc_q      <= '0;
         replay_instr_q   <= '0;
         flush_q          <= 1'b0;
         redirect_valid_q <= 1'b0;
         redirect_pc_q    <= '0;
      end else begin
         state_q          <= state_d;
         tag_pc_q         <= tag_pc_d;
         tag_tgt_q        <= tag_tgt_d;
         iter_q           <= iter_d;
         wr_ptr_q         <= wr_ptr_d;
         rd_ptr_q         <= rd_ptr_d;
         loop_len_q       <= loop_len_d;
         fetch_block_q    <= fetch_block_d;
         replay_valid_q   <= replay_valid_d;
         replay_pc_q      <= replay_pc_d;
         replay_instr_q   <= replay_instr_d;
         flush_q          <= flush_d;
         redirect_valid_q <= redirect_valid_d;
         redirect_pc_q    <= redirect_pc_d;
      end
   end

   // Loop body store: one write port during capture, no reset.
   always_ff @(posedge clk) begin
      if (mem_we && !reset) begin
         mem_q[wr_ptr_q] <= if_instr;
      end
   end

   assign state          = state_q;
   assign loop_len       = loop_len_q;
   assign fetch_block    = fetch_block_q;
   assign replay_valid   = replay_valid_q;
   assign replay_pc      = replay_pc_q;
   assign replay_instr   = replay_instr_q;
   assign flush          = flush_q;
   assign redirect_valid = redirect_valid_q;
   assign redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_loop_replay_controller.sv
// Bench for loop_replay_controller: directed loop scenarios followed by
// randomized loops, checked cycle by cycle against a queue-based model.
module tb_loop_replay_controller;

   localparam int DEPTH       = 16;
   localparam int PTR_W       = 4;
   localparam int TRIP_THRESH = 2;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             if_valid = 1'b0;
   logic [31:0]      if_pc = '0;
   logic [31:0]      if_instr = '0;
   logic             br_taken = 1'b0;
   logic [31:0]      br_pc = '0;
   logic [31:0]      br_target = '0;
   logic             mispredict = 1'b0;
   logic [31:0]      mispredict_pc = '0;
   logic             stall = 1'b0;
   logic             fetch_block;
   logic             replay_valid;
   logic [31:0]      replay_pc;
   logic [31:0]      replay_instr;
   logic             flush;
   logic             redirect_valid;
   logic [31:0]      redirect_pc;
   logic [1:0]       state;
   logic [PTR_W:0]   loop_len;

   loop_replay_controller #(
      .DEPTH(DEPTH), .PTR_W(PTR_W), .TRIP_THRESH(TRIP_THRESH)
   ) dut (
      .clk(clk), .reset(reset), .if_valid(if_valid), .if_pc(if_pc),
      .if_instr(if_instr), .br_taken(br_taken), .br_pc(br_pc),
      .br_target(br_target), .mispredict(mispredict),
      .mispredict_pc(mispredict_pc), .stall(stall),
      .fetch_block(fetch_block), .replay_valid(replay_valid),
      .replay_pc(replay_pc), .replay_instr(replay_instr), .flush(flush),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .state(state), .loop_len(loop_len)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  st;
      logic        fb;
      logic        rv;
      logic [31:0] rpc;
      logic [31:0] rin;
      logic        fl;
      logic        redv;
      logic [31:0] redpc;
      logic [31:0] len;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model: loop body kept as queues of captured (pc, instr).
   int          m_st = 0;
   logic [31:0] m_tag_pc = '0;
   logic [31:0] m_tag_tgt = '0;
   int          m_iter = 0;
   logic [31:0] m_body_pc[$];
   logic [31:0] m_body_in[$];
   int          m_idx = 0;

   logic [31:0] body_instr [32];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic bit is_cand(input logic bt, input logic [31:0] bp, input logic [31:0] tg);
      logic [31:0] blen;
      blen = ((bp - tg) >> 2) + 32'd1;
      return bt && (tg < bp) && (bp[1:0] == 2'b00) && (tg[1:0] == 2'b00) && (blen <= 32'(DEPTH));
   endfunction

   task automatic model_step();
      exp_t        e;
      logic        fl;
      logic [31:0] rpc;
      logic [31:0] want;
      bit          c;
      fl  = 1'b0;
      rpc = '0;
      c   = is_cand(br_taken, br_pc, br_target);
      if (reset) begin
         m_st = 0; m_iter = 0; m_idx = 0;
         m_body_pc.delete(); m_body_in.delete();
      end else if (mispredict) begin
         if (m_st == 3) begin
            fl  = 1'b1;
            rpc = mispredict_pc;
         end
         m_st = 0;
      end else begin
         case (m_st)
            0: if (c) begin
               m_tag_pc = br_pc; m_tag_tgt = br_target; m_iter = 1;
               m_body_pc.delete(); m_body_in.delete();
               m_st = (TRIP_THRESH == 1) ? 2 : 1;
            end
            1: begin
               if (c && br_pc == m_tag_pc && br_target == m_tag_tgt) begin
                  m_iter++;
                  if (m_iter == TRIP_THRESH) begin
                     m_st = 2;
                     m_body_pc.delete(); m_body_in.delete();
                  end
               end else if (c) begin
                  m_tag_pc = br_pc; m_tag_tgt = br_target; m_iter = 1;
               end else if (br_taken) begin
                  m_st = 0;
               end
            end
            2: if (if_valid) begin
               want = m_tag_tgt + 32'(4 * m_body_pc.size());
               if (if_pc == want) begin
                  m_body_pc.push_back(if_pc);
                  m_body_in.push_back(if_instr);
                  if (if_pc == m_tag_pc) begin
                     m_st = 3; m_idx = 0;
                  end else if (m_body_pc.size() == DEPTH) begin
                     m_st = 0;
                  end
               end else begin
                  m_st = 0;
               end
            end
            default: if (!stall) m_idx = (m_idx + 1) % m_body_pc.size();
         endcase
      end
      e.st    = 2'(m_st);
      e.fb    = (m_st == 3);
      e.rv    = (m_st == 3);
      e.rpc   = (m_st == 3) ? m_body_pc[m_idx] : '0;
      e.rin   = (m_st == 3) ? m_body_in[m_idx] : '0;
      e.len   = (m_st == 3) ? 32'(m_body_pc.size()) : '0;
      e.fl    = fl;
      e.redv  = fl;
      e.redpc = rpc;
      exp_q.push_back(e);
   endtask

   // Monitor: compares the DUT's registered outputs just after each edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("state", 32'(state), 32'(e.st));
            chk("fetch_block", 32'(fetch_block), 32'(e.fb));
            chk("replay_valid", 32'(replay_valid), 32'(e.rv));
            chk("loop_len", 32'(loop_len), e.len);
            chk("flush", 32'(flush), 32'(e.fl));
            chk("redirect_valid", 32'(redirect_valid), 32'(e.redv));
            chk("redirect_pc", redirect_pc, e.redpc);
            if (e.rv) begin
               chk("replay_pc", replay_pc, e.rpc);
               chk("replay_instr", replay_instr, e.rin);
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   task automatic clear_in();
      reset = 1'b0; if_valid = 1'b0; br_taken = 1'b0; mispredict = 1'b0; stall = 1'b0;
   endtask

   task automatic step();
      model_step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic run_loop(input logic [31:0] base, input int len, input int iters, input bit rnd);
      for (int it = 0; it < iters; it++) begin
         for (int k = 0; k < len; k++) begin
            if (rnd && $urandom_range(0, 3) == 0) begin
               clear_in();
               step();
            end
            clear_in();
            if_valid = 1'b1;
            if_pc    = base + 32'(4 * k);
            if_instr = body_instr[k];
            if (k == len - 1) begin
               br_taken  = 1'b1;
               br_pc     = if_pc;
               br_target = base;
            end
            if (rnd && $urandom_range(0, 39) == 0) begin
               mispredict    = 1'b1;
               mispredict_pc = $urandom & 32'hFFFF_FFFC;
            end
            step();
         end
      end
      clear_in();
   endtask

   initial begin
      logic [31:0] base;
      int          len;
      // Reset and a mid-TRAIN reset
      reset = 1'b1; step(); step();
      chk("reset_state", 32'(state), 32'd0);
      clear_in();
      body_instr[0] = 32'h13; body_instr[1] = 32'h14;
      body_instr[2] = 32'h15; body_instr[3] = 32'hFC000AE3;
      run_loop(32'h100, 4, 1, 1'b0);
      chk("train_state", 32'(state), 32'd1);
      reset = 1'b1; step(); step();
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_fetch_block", 32'(fetch_block), 32'd0);
      chk("rst_replay_valid", 32'(replay_valid), 32'd0);
      chk("rst_flush", 32'(flush), 32'd0);
      chk("rst_redirect_valid", 32'(redirect_valid), 32'd0);
      chk("rst_loop_len", 32'(loop_len), 32'd0);
      clear_in();

      // Train, capture and replay a 4-instruction loop
      run_loop(32'h100, 4, 3, 1'b0);
      chk("rep_state", 32'(state), 32'd3);
      chk("rep_loop_len", 32'(loop_len), 32'd4);
      chk("rep_fetch_block", 32'(fetch_block), 32'd1);
      chk("rep_pc0", replay_pc, 32'h100);
      chk("rep_in0", replay_instr, 32'h13);
      step();
      chk("rep_pc1", replay_pc, 32'h104);
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("stall_pc", replay_pc, 32'h104);
         chk("stall_in", replay_instr, 32'h14);
      end
      stall = 1'b0;
      step();
      chk("rep_pc2", replay_pc, 32'h108);
      step();
      chk("rep_in3", replay_instr, 32'hFC000AE3);
      step();
      chk("rep_wrap_pc", replay_pc, 32'h100);
      chk("rep_wrap_in", replay_instr, 32'h13);
      mispredict = 1'b1; mispredict_pc = 32'h110;
      step();
      chk("exit_flush", 32'(flush), 32'd1);
      chk("exit_redirect_valid", 32'(redirect_valid), 32'd1);
      chk("exit_redirect_pc", redirect_pc, 32'h110);
      chk("exit_state", 32'(state), 32'd0);
      chk("exit_fetch_block", 32'(fetch_block), 32'd0);
      clear_in();
      step();
      chk("post_flush", 32'(flush), 32'd0);
      chk("post_redirect_valid", 32'(redirect_valid), 32'd0);

      // Length-17 branch is not a candidate
      br_taken = 1'b1; br_pc = 32'h140; br_target = 32'h100;
      step(); clear_in(); step();
      chk("len17_state", 32'(state), 32'd0);

      // Full-depth loop
      for (int k = 0; k < 16; k++) body_instr[k] = $urandom;
      run_loop(32'h100, 16, 3, 1'b0);
      chk("len16_state", 32'(state), 32'd3);
      chk("len16_loop_len", 32'(loop_len), 32'd16);
      for (int i = 0; i < 40; i++) begin
         stall = ($urandom_range(0, 2) == 0);
         step();
      end
      clear_in();
      mispredict = 1'b1; mispredict_pc = 32'h2000;
      step(); clear_in(); step();

      // Capture abort on a PC jump
      body_instr[0] = 32'h13; body_instr[1] = 32'h14;
      body_instr[2] = 32'h15; body_instr[3] = 32'hFC000AE3;
      run_loop(32'h100, 4, 2, 1'b0);
      chk("cap_state", 32'(state), 32'd2);
      if_valid = 1'b1; if_pc = 32'h100; if_instr = 32'h13; step();
      if_pc = 32'h104; if_instr = 32'h14; step();
      if_pc = 32'h200; if_instr = 32'h99; step();
      chk("abort_state", 32'(state), 32'd0);
      clear_in();
      for (int i = 0; i < 4; i++) step();
      chk("abort_no_replay", 32'(replay_valid), 32'd0);

      // Mispredict beats a same-tag candidate in TRAIN
      run_loop(32'h100, 4, 1, 1'b0);
      chk("mp_train_state", 32'(state), 32'd1);
      for (int k = 0; k < 4; k++) begin
         if_valid = 1'b1; if_pc = 32'h100 + 32'(4 * k); if_instr = body_instr[k];
         if (k == 3) begin
            br_taken = 1'b1; br_pc = 32'h10C; br_target = 32'h100;
            mispredict = 1'b1; mispredict_pc = 32'h300;
         end
         step();
      end
      chk("mp_cand_state", 32'(state), 32'd0);
      clear_in();
      step();

      // Randomized loops
      for (int ep = 0; ep < 30; ep++) begin
         len  = $urandom_range(2, 18);
         base = 32'h1000 + 32'(4 * $urandom_range(0, 1023));
         for (int k = 0; k < len; k++) body_instr[k] = $urandom;
         if ($urandom_range(0, 3) == 0) begin
            for (int i = 0; i < 4; i++) begin
               br_taken  = $urandom_range(0, 1);
               br_pc     = base + ($urandom & 32'h7F);
               br_target = base + ($urandom & 32'h3F);
               step();
            end
            clear_in();
         end
         run_loop(base, len, $urandom_range(1, 4), 1'b1);
         for (int i = 0; i < 30; i++) begin
            stall = ($urandom_range(0, 2) == 0);
            step();
         end
         clear_in();
         if ($urandom_range(0, 1) == 0) begin
            mispredict = 1'b1; mispredict_pc = $urandom & 32'hFFFF_FFFC;
         end else begin
            reset = 1'b1;
         end
         step();
         clear_in();
         step();
      end

      step();
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
      #2;
      if (exp_q.size() > 0) chk("drain", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
